data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// Parametrised data memory for the CPU load/store stage. Successor to the fixed single-cycle Memory.
// Adds a valid/ready request channel and a held response channel.
// Read latency is configurable; loads may be signed or unsigned.
// Misaligned, illegal-size and out-of-range accesses are flagged with an error.
// At most one request is outstanding at a time.
// PARAMETERS
// ADDR_WIDTH    32      byte-address width
// DEPTH_WORDS   1024    number of 32-bit words stored
// READ_LATENCY  1       cycles from read accept to resp_valid; legal range 1..4
// BASE_ADDR     0       byte address of word 0; must be 4-byte aligned
// PORTS
// clk           in   1           clock, rising edge
// rst           in   1           asynchronous active-high reset
// req_valid     in   1           request present
// req_ready     out  1           block can accept a request
// req_write     in   1           1 = store, 0 = load
// req_size      in   2           00 byte, 01 half, 10 word, 11 illegal
// req_unsigned  in   1           1 = zero-extend loads, 0 = sign-extend
// req_addr      in   ADDR_WIDTH  byte address
// req_wdata     in   32          store data, taken from the low bits
// resp_valid    out  1           response present
// resp_ready    in   1           consumer takes the response
// resp_rdata    out  32          load result; 0 for stores and errors
// resp_error    out  1           access was rejected
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
// - Memory contents are not reset.
// - States: IDLE -> (read) WAIT -> RESP; IDLE -> (write or error) RESP; RESP -> IDLE.
// - req_ready is 1 only in IDLE. A request is accepted on an edge where req_valid && req_ready.
// - Error check at accept. Any one of these sets resp_error:
//   - size 11;
//   - half with addr[0]!=0;
//   - word with addr[1:0]!=0;
//   - (addr-BASE_ADDR) >= 4*DEPTH_WORDS, or addr < BASE_ADDR.
// - Errored requests: no memory update; go to RESP next edge with rdata=0.
// - Store: byte lanes are written on the accept edge. Little-endian.
//   - byte: lane addr[1:0] <- wdata[7:0];
//   - half: lanes {addr[1]*2+1, addr[1]*2} <- wdata[15:0];
//   - word: all four lanes <- wdata.
//   - Response on the next edge: resp_valid=1, rdata=0, error=0.
// - Load: memory is sampled at the accept edge.
//   - resp_valid rises exactly READ_LATENCY edges after accept.
//   - READ_LATENCY=1 skips WAIT; WAIT uses a down-counter.
//   - Byte/half selection uses addr[1:0] / addr[1]; result is sign- or zero-extended per req_unsigned.
// - RESP: resp_valid, resp_rdata and resp_error are held stable until an edge with resp_ready=1.
//   - On that edge: resp_valid -> 0, rdata/error -> 0, state -> IDLE.
//   - req_ready returns to 1 in the following cycle (no same-cycle turnaround).
// - Requests are ignored while req_ready=0, and are not queued.
// - Reset mid-operation: the pending response is discarded and outputs return to reset values immediately.
//   - A store accepted before reset remains committed.
// - req_* inputs are ignored outside the accept edge; later changes do not affect an in-flight access.
// TESTING
// - Word store 0x12345678 @0x0, then load word @0x0 -> rdata 0x12345678, error 0.
//   - Check resp_valid READ_LATENCY edges after accept, for latencies 1 and 3.
// - Half store 0xABCD @0x4 -> signed load 0xFFFFABCD; unsigned load 0x0000ABCD.
//   - Byte 0xFF @0x8 -> signed load 0xFFFFFFFF.
// - Word 0x12345678 @0x10 -> half @0x12 = 0x00001234; byte @0x13 = 0x00000012; byte @0x11 = 0x00000056.
// - Word store @0x2, half load @0x5, size 11, addr 4*DEPTH_WORDS -> each gives resp_error=1, rdata=0.
//   - Prior memory contents are unchanged.
// - Hold resp_ready=0 for 3 cycles -> resp_valid, rdata and error stay stable and req_ready=0.
//   - A new req_valid during that time is not accepted.
// - Assert rst during WAIT (READ_LATENCY=4) -> resp_valid stays 0; req_ready=1 once reset releases.
//   - A load issued next is served normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory for the load/store stage.
// Valid/ready request channel, held response channel, configurable read
// latency, signed/unsigned sub-word loads and access error detection.
module data_mem_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;
  logic                  size_err;
  logic                  align_err;
  logic                  range_err;
  logic                  acc_err;
  logic                  do_store;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shifted;
  logic [31:0]           load_value;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [2:0]            cnt_q;

  assign accept   = req_valid && req_ready;
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign do_store = accept && req_write && !acc_err;
  assign rd_word  = mem[word_idx];

  // Classify the presented request: bad size, misalignment or outside the window
  always_comb begin
    size_err  = (req_size == 2'b11);
    align_err = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    range_err = (req_addr < BASE_ADDR) || ({1'b0, offset} >= MEM_BYTES);
    acc_err   = size_err || align_err || range_err;
  end

  // Replicate store data across lanes and pick which lanes this store touches
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  // Extract and extend the addressed byte/half/word from the stored word
  always_comb begin
    rd_shifted = rd_word >> {req_addr[1:0], 3'b000};
    load_value = rd_word;
    case (req_size)
      2'b00:   load_value = req_unsigned ? {24'h0, rd_shifted[7:0]}
                                         : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_value = req_unsigned ? {16'h0, rd_shifted[15:0]}
                                         : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_value = rd_word;
    endcase
  end

  // Storage array: lane-masked writes on the accept edge, contents never reset
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: loads wait out the latency, everything else responds at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_write && !acc_err && (READ_LATENCY > 1)) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload and latency counter, captured at accept and held until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else if (accept) begin
      rdata_q <= (req_write || acc_err) ? 32'h0 : load_value;
      err_q   <= acc_err;
      cnt_q   <= CNT_INIT;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 3'd1;
    end else if ((state_q == RESP) && resp_ready) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end
  end

  // Outputs decoded from state; payload only visible while a response is presented
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
    resp_error = (state_q == RESP) ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for data_mem_ctrl using three
// instances with read latencies 1, 3 and 4.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst          [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_write    [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        resp_valid   [3];
  logic        resp_ready   [3];
  logic [31:0] resp_rdata   [3];
  logic        resp_error   [3];

  int   lat_cfg [3] = '{1, 3, 4};
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  // Free-running clock
  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

  data_mem_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(3), .BASE_ADDR(32'h0)) dut_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

  data_mem_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(4), .BASE_ADDR(32'h0)) dut_l4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  // Single comparison point: counts, and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full request/response transaction on instance d, optionally stalling the consumer
  task automatic applyStimulus(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input bit exp_err,
                               input bit hold, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = (wr || exp_err) ? 1 : lat_cfg[d];
    @(negedge clk);
    checkOutput({tag, "/req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom);
    req_size[d]     = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    req_addr[d]     = $urandom;
    req_wdata[d]    = $urandom;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb.pop_front();
    checkOutput({tag, "/latency"}, 32'(lat), 32'(got.lat));
    checkOutput({tag, "/rdata"}, resp_rdata[d], got.rdata);
    checkOutput({tag, "/error"}, 32'(resp_error[d]), 32'(got.err));
    checkOutput({tag, "/req_ready_busy"}, 32'(req_ready[d]), 32'd0);
    if (hold) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_size[d]  = 2'b10;
      req_addr[d]  = addr;
      req_wdata[d] = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s/hold%0d_valid", tag, i), 32'(resp_valid[d]), 32'd1);
        checkOutput($sformatf("%s/hold%0d_rdata", tag, i), resp_rdata[d], got.rdata);
        checkOutput($sformatf("%s/hold%0d_error", tag, i), 32'(resp_error[d]), 32'(got.err));
        checkOutput($sformatf("%s/hold%0d_ready", tag, i), 32'(req_ready[d]), 32'd0);
      end
    end
    @(negedge clk);
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    checkOutput({tag, "/valid_drop"}, 32'(resp_valid[d]), 32'd0);
    checkOutput({tag, "/rdata_clear"}, resp_rdata[d], 32'h0);
    checkOutput({tag, "/ready_back"}, 32'(req_ready[d]), 32'd1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]          = 1'b1;
      req_valid[i]    = 1'b0;
      req_write[i]    = 1'b0;
      req_size[i]     = 2'b00;
      req_unsigned[i] = 1'b0;
      req_addr[i]     = 32'h0;
      req_wdata[i]    = 32'h0;
      resp_ready[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d/req_ready", i), 32'(req_ready[i]), 32'd1);
      checkOutput($sformatf("reset%0d/resp_valid", i), 32'(resp_valid[i]), 32'd0);
      checkOutput($sformatf("reset%0d/resp_rdata", i), resp_rdata[i], 32'h0);
      checkOutput($sformatf("reset%0d/resp_error", i), 32'(resp_error[i]), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Latency 1 instance
    applyStimulus(0, 1, 2'b10, 0, 32'h0, 32'h12345678, 32'h0, 0, 0, "l1_sw0");
    applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, "l1_lw0");

    // Latency 3 instance: word, half, byte stores and loads
    applyStimulus(1, 1, 2'b10, 0, 32'h0, 32'h12345678, 32'h0, 0, 0, "l3_sw0");
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, "l3_lw0");
    applyStimulus(1, 1, 2'b01, 0, 32'h4, 32'h7777ABCD, 32'h0, 0, 0, "sh4");
    applyStimulus(1, 0, 2'b01, 0, 32'h4, 32'h0, 32'hFFFFABCD, 0, 0, "lh4_s");
    applyStimulus(1, 0, 2'b01, 1, 32'h4, 32'h0, 32'h0000ABCD, 0, 0, "lh4_u");
    applyStimulus(1, 1, 2'b00, 0, 32'h8, 32'h123456FF, 32'h0, 0, 0, "sb8");
    applyStimulus(1, 0, 2'b00, 0, 32'h8, 32'h0, 32'hFFFFFFFF, 0, 0, "lb8_s");
    applyStimulus(1, 0, 2'b00, 1, 32'h8, 32'h0, 32'h000000FF, 0, 0, "lb8_u");
    applyStimulus(1, 1, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0, 0, "sw10");
    applyStimulus(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h00001234, 0, 0, "lh12");
    applyStimulus(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h00000012, 0, 0, "lb13");
    applyStimulus(1, 0, 2'b00, 0, 32'h11, 32'h0, 32'h00000056, 0, 0, "lb11");
    applyStimulus(1, 1, 2'b00, 0, 32'h11, 32'h000000EE, 32'h0, 0, 0, "sb11");
    applyStimulus(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234EE78, 0, 0, "lw10_merge");
    applyStimulus(1, 1, 2'b10, 0, 32'h14, 32'h80FF7F01, 32'h0, 0, 0, "sw14");
    applyStimulus(1, 0, 2'b00, 0, 32'h16, 32'h0, 32'hFFFFFFFF, 0, 0, "lb16_s");
    applyStimulus(1, 0, 2'b00, 0, 32'h17, 32'h0, 32'hFFFFFF80, 0, 0, "lb17_s");
    applyStimulus(1, 0, 2'b00, 0, 32'h15, 32'h0, 32'h0000007F, 0, 0, "lb15_s");
    applyStimulus(1, 0, 2'b01, 0, 32'h14, 32'h0, 32'h00007F01, 0, 0, "lh14_s");
    applyStimulus(1, 0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFF80FF, 0, 0, "lh16_s");

    // Error cases, with memory left untouched
    applyStimulus(1, 1, 2'b10, 0, 32'h2, 32'hFFFFFFFF, 32'h0, 1, 0, "err_sw_mis");
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, "after_sw_mis");
    applyStimulus(1, 0, 2'b01, 0, 32'h5, 32'h0, 32'h0, 1, 0, "err_lh_mis");
    applyStimulus(1, 1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 0, "err_size");
    applyStimulus(1, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 0, "err_size_ld");
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, "after_size");
    applyStimulus(1, 1, 2'b10, 0, 32'(4*DEPTH - 4), 32'hA5A5A5A5, 32'h0, 0, 0, "sw_last");
    applyStimulus(1, 0, 2'b10, 0, 32'(4*DEPTH - 4), 32'h0, 32'hA5A5A5A5, 0, 0, "lw_last");
    applyStimulus(1, 1, 2'b10, 0, 32'(4*DEPTH), 32'hFFFFFFFF, 32'h0, 1, 0, "err_range_st");
    applyStimulus(1, 0, 2'b10, 0, 32'(4*DEPTH), 32'h0, 32'h0, 1, 0, "err_range_ld");
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, "after_range");

    // Consumer stall with a competing request that must be ignored
    applyStimulus(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0, "sw20");
    applyStimulus(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, "lw20_hold");
    applyStimulus(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0, "lw20_after");

    // Latency 4 instance: reset in WAIT, then reset after an accepted store
    applyStimulus(2, 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0, 0, 0, "l4_sw40");
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_size[2]  = 2'b10;
    req_addr[2]  = 32'h40;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_wait/in_wait_valid", 32'(resp_valid[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    checkOutput("rst_wait/during_valid", 32'(resp_valid[2]), 32'd0);
    checkOutput("rst_wait/during_rdata", resp_rdata[2], 32'h0);
    @(negedge clk);
    rst[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_wait/post%0d_valid", i), 32'(resp_valid[2]), 32'd0);
      checkOutput($sformatf("rst_wait/post%0d_ready", i), 32'(req_ready[2]), 32'd1);
    end
    applyStimulus(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0, 0, "l4_lw40");

    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_size[2]  = 2'b10;
    req_addr[2]  = 32'h44;
    req_wdata[2] = 32'h55AA55AA;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    checkOutput("rst_resp/valid_before", 32'(resp_valid[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    checkOutput("rst_resp/valid_during", 32'(resp_valid[2]), 32'd0);
    checkOutput("rst_resp/ready_during", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    rst[2] = 1'b0;
    applyStimulus(2, 0, 2'b10, 0, 32'h44, 32'h0, 32'h55AA55AA, 0, 0, "l4_lw44");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
